// File: rtl/battleship_link_if.sv
// -----------------------------------------------------------------------------
// battleship_link_if
//   Local message interface between the game-logic controller and the
//   battleship_link transceiver.
//
//   tx_data    [15:0]  controller -> link  message to send
//   tx_valid           controller -> link  tx_data valid
//   tx_ready           link -> controller  link can accept a message
//   tx_timeout         link -> controller  one-cycle pulse: message aborted
//   rx_data    [15:0]  link -> controller  last received message
//   rx_valid           link -> controller  one-cycle pulse: rx_data updated
//
//   master: the controller side.  slave: the transceiver side.
// -----------------------------------------------------------------------------
interface battleship_link_if;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_timeout;
   logic [15:0] rx_data;
   logic        rx_valid;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_timeout, rx_data, rx_valid
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_timeout, rx_data, rx_valid
   );
endinterface

// File: rtl/battleship_link.sv
// -----------------------------------------------------------------------------
// battleship_link
//   Full-duplex board-to-board transceiver. 16-bit messages are moved as four
//   4-bit nibbles (MSB nibble first) using a toggle request/acknowledge
//   handshake on a 6-bit pin pair.
//
//   clk_clk               in   system clock
//   reset_reset           in   synchronous, active-high reset
//   link                  slave modport of battleship_link_if (tx/rx ports)
//   communication_input   in   [5] remote req, [4] remote ack, [3:0] nibble
//   communication_output  out  [5] local req,  [4] local ack,  [3:0] nibble
//
//   TIMEOUT_CYCLES : cycles without remote progress before a TX abort or an
//                    RX partial-frame discard.
//   SYNC_STAGES    : synchroniser depth on communication_input (>= 2).
// -----------------------------------------------------------------------------
module battleship_link #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   battleship_link_if.slave link,
   input  logic [5:0]       communication_input,
   output logic [5:0]       communication_output
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      REQ,
      WAIT_ACK
   } tx_state_e;

   // ---------------------------------------------------------------------------
   // Input synchroniser: only the last stage is ever looked at.
   // ---------------------------------------------------------------------------
   logic [5:0] sync_d [SYNC_STAGES];
   logic [5:0] sync_q [SYNC_STAGES];

   always_comb begin
      sync_d[0] = communication_input;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   logic       remote_req;
   logic       remote_ack;
   logic [3:0] remote_nib;

   assign remote_req = sync_q[SYNC_STAGES-1][5];
   assign remote_ack = sync_q[SYNC_STAGES-1][4];
   assign remote_nib = sync_q[SYNC_STAGES-1][3:0];

   // ---------------------------------------------------------------------------
   // TX state
   // ---------------------------------------------------------------------------
   tx_state_e   tx_state_d,   tx_state_q;
   logic [11:0] tx_rest_d,    tx_rest_q;     // nibbles still to be sent, next in [11:8]
   logic [1:0]  tx_idx_d,     tx_idx_q;
   logic [3:0]  nib_d,        nib_q;         // drives out[3:0]
   logic        req_d,        req_q;         // drives out[5]
   logic [CW-1:0] tx_cnt_d,   tx_cnt_q;
   logic        tx_timeout_d, tx_timeout_q;
   logic        tx_ready_d,   tx_ready_q;

   // NOTE: every signal assigned in an always_comb gets a default at the top,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      tx_state_d   = tx_state_q;
      tx_rest_d    = tx_rest_q;
      tx_idx_d     = tx_idx_q;
      nib_d        = nib_q;
      req_d        = req_q;
      tx_cnt_d     = tx_cnt_q;
      tx_timeout_d = 1'b0;

      case (tx_state_q)
         IDLE: begin
            if (link.tx_valid && tx_ready_q) begin
               // The first nibble is put on the pins on entry to SETUP, so it
               // is stable for a full cycle before req toggles.
               nib_d      = link.tx_data[15:12];
               tx_rest_d  = link.tx_data[11:0];
               tx_idx_d   = 2'd0;
               tx_state_d = SETUP;
            end
         end
         SETUP: begin
            tx_state_d = REQ;
         end
         REQ: begin
            req_d      = ~req_q;
            tx_cnt_d   = '0;
            tx_state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (remote_ack == req_q) begin
               if (tx_idx_q == 2'd3) begin
                  tx_state_d = IDLE;
               end else begin
                  tx_idx_d   = tx_idx_q + 2'd1;
                  nib_d      = tx_rest_q[11:8];
                  tx_rest_d  = {tx_rest_q[7:0], 4'h0};
                  tx_state_d = SETUP;
               end
            end else if (tx_cnt_q == CNT_LAST) begin
               // req is left toggled: the remote acks it whenever it catches up,
               // which keeps both ends phase-consistent for the next message.
               tx_timeout_d = 1'b1;
               tx_state_d   = IDLE;
            end else if (tx_cnt_q != '1) begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = IDLE;
      endcase

      tx_ready_d = (tx_state_d == IDLE);
   end

   // ---------------------------------------------------------------------------
   // RX state
   // ---------------------------------------------------------------------------
   logic        ack_d,      ack_q;           // drives out[4]
   logic [11:0] rx_shift_d, rx_shift_q;      // first three nibbles of a frame
   logic [1:0]  rx_cnt_d,   rx_cnt_q;
   logic [CW-1:0] gap_d,    gap_q;
   logic [15:0] rx_data_d,  rx_data_q;
   logic        rx_valid_d, rx_valid_q;

   logic        rx_new;
   logic [15:0] rx_word;

   // The 4th nibble completes the word directly from the shift register, so
   // only three nibbles ever need to be held.
   assign rx_new  = (remote_req != ack_q);
   assign rx_word = {rx_shift_q, remote_nib};

   always_comb begin
      ack_d      = ack_q;
      rx_shift_d = rx_shift_q;
      rx_cnt_d   = rx_cnt_q;
      gap_d      = gap_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;

      if (rx_new) begin
         ack_d      = ~ack_q;
         rx_shift_d = rx_word[11:0];
         gap_d      = '0;
         if (rx_cnt_q == 2'd3) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            rx_cnt_d   = 2'd0;
         end else begin
            rx_cnt_d = rx_cnt_q + 2'd1;
         end
      end else if (rx_cnt_q != 2'd0) begin
         if (gap_q == CNT_LAST) begin
            // Remote stalled mid-frame: drop the partial word silently.
            rx_cnt_d   = 2'd0;
            rx_shift_d = '0;
            gap_d      = '0;
         end else if (gap_q != '1) begin
            gap_d = gap_q + 1'b1;
         end
      end else begin
         gap_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before this edge regardless of statement order.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         // NOTE: the synchroniser array is a handful of flops, not a RAM, so
         // it is cleared by reset like any other state.
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         tx_state_q   <= IDLE;
         tx_rest_q    <= '0;
         tx_idx_q     <= '0;
         nib_q        <= '0;
         req_q        <= 1'b0;
         tx_cnt_q     <= '0;
         tx_timeout_q <= 1'b0;
         tx_ready_q   <= 1'b1;
         ack_q        <= 1'b0;
         rx_shift_q   <= '0;
         rx_cnt_q     <= '0;
         gap_q        <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         tx_state_q   <= tx_state_d;
         tx_rest_q    <= tx_rest_d;
         tx_idx_q     <= tx_idx_d;
         nib_q        <= nib_d;
         req_q        <= req_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_timeout_q <= tx_timeout_d;
         tx_ready_q   <= tx_ready_d;
         ack_q        <= ack_d;
         rx_shift_q   <= rx_shift_d;
         rx_cnt_q     <= rx_cnt_d;
         gap_q        <= gap_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
      end
   end

   assign communication_output = {req_q, ack_q, nib_q};
   assign link.tx_ready        = tx_ready_q;
   assign link.tx_timeout      = tx_timeout_q;
   assign link.rx_data         = rx_data_q;
   assign link.rx_valid        = rx_valid_q;

endmodule

// File: tb/tb_battleship_link.sv
// -----------------------------------------------------------------------------
// tb_battleship_link
//   Two instances (a, b) cross-wired in loopback, plus a third instance (c)
//   whose remote pins are driven by the bench. Expected traffic is kept as
//   per-receiver queues of whole words; timing expectations come from the
//   protocol's cycle rules.
// -----------------------------------------------------------------------------
module tb_battleship_link;

   localparam int TO_AB = 64;
   localparam int TO_C  = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   battleship_link_if if_a ();
   battleship_link_if if_b ();
   battleship_link_if if_c ();

   logic [5:0] a_out, b_out, c_in, c_out;

   battleship_link #(.TIMEOUT_CYCLES(TO_AB), .SYNC_STAGES(2)) u_a (
      .clk_clk              (clk),
      .reset_reset          (rst),
      .link                 (if_a.slave),
      .communication_input  (b_out),
      .communication_output (a_out)
   );

   battleship_link #(.TIMEOUT_CYCLES(TO_AB), .SYNC_STAGES(2)) u_b (
      .clk_clk              (clk),
      .reset_reset          (rst),
      .link                 (if_b.slave),
      .communication_input  (a_out),
      .communication_output (b_out)
   );

   battleship_link #(.TIMEOUT_CYCLES(TO_C), .SYNC_STAGES(2)) u_c (
      .clk_clk              (clk),
      .reset_reset          (rst),
      .link                 (if_c.slave),
      .communication_input  (c_in),
      .communication_output (c_out)
   );

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: collects received words, timeout pulses and pin toggles.
   // ---------------------------------------------------------------------------
   logic [15:0] got_a[$], got_b[$], got_c[$];
   int to_a = 0, to_b = 0, to_c = 0;
   int tog_a5 = 0, tog_b4 = 0;
   logic [5:0] pa = '0, pb = '0;

   always @(negedge clk) begin
      if (if_a.rx_valid === 1'b1) got_a.push_back(if_a.rx_data);
      if (if_b.rx_valid === 1'b1) got_b.push_back(if_b.rx_data);
      if (if_c.rx_valid === 1'b1) got_c.push_back(if_c.rx_data);
      if (if_a.tx_timeout === 1'b1) to_a++;
      if (if_b.tx_timeout === 1'b1) to_b++;
      if (if_c.tx_timeout === 1'b1) to_c++;
      if (a_out[5] !== pa[5]) tog_a5++;
      if (b_out[4] !== pb[4]) tog_b4++;
      pa = a_out;
      pb = b_out;
   end

   // ---------------------------------------------------------------------------
   // Reference model: words each receiver must deliver, in order.
   // ---------------------------------------------------------------------------
   logic [15:0] exp_a[$], exp_b[$], exp_c[$];
   int cur_a = 0, cur_b = 0, cur_c = 0;

   task automatic verify_rx();
      check("rx_count_a", 32'(got_a.size()), 32'(exp_a.size()));
      check("rx_count_b", 32'(got_b.size()), 32'(exp_b.size()));
      check("rx_count_c", 32'(got_c.size()), 32'(exp_c.size()));
      for (int k = cur_a; k < exp_a.size() && k < got_a.size(); k++)
         check("rx_word_a", 32'(got_a[k]), 32'(exp_a[k]));
      for (int k = cur_b; k < exp_b.size() && k < got_b.size(); k++)
         check("rx_word_b", 32'(got_b[k]), 32'(exp_b[k]));
      for (int k = cur_c; k < exp_c.size() && k < got_c.size(); k++)
         check("rx_word_c", 32'(got_c[k]), 32'(exp_c[k]));
      cur_a = exp_a.size();
      cur_b = exp_b.size();
      cur_c = exp_c.size();
   endtask

   function automatic logic rdy(input int w);
      case (w)
         0:       return if_a.tx_ready;
         1:       return if_b.tx_ready;
         default: return if_c.tx_ready;
      endcase
   endfunction

   task automatic drive_tx(input int w, input logic v, input logic [15:0] d);
      case (w)
         0:       begin if_a.tx_valid = v; if_a.tx_data = d; end
         1:       begin if_b.tx_valid = v; if_b.tx_data = d; end
         default: begin if_c.tx_valid = v; if_c.tx_data = d; end
      endcase
   endtask

   task automatic wait_ready(input int w);
      int i = 0;
      @(negedge clk);
      while (rdy(w) !== 1'b1 && i < 3000) begin
         @(negedge clk);
         i++;
      end
      check("tx_ready_wait", 32'(rdy(w)), 32'd1);
   endtask

   // Present one message and hold valid for exactly the accepting edge.
   task automatic send(input int w, input logic [15:0] d);
      wait_ready(w);
      drive_tx(w, 1'b1, d);
      if (w == 0) exp_b.push_back(d);
      if (w == 1) exp_a.push_back(d);
      @(negedge clk);
      drive_tx(w, 1'b0, d);
   endtask

   task automatic send_both(input logic [15:0] da, input logic [15:0] db);
      wait_ready(0);
      wait_ready(1);
      drive_tx(0, 1'b1, da);
      drive_tx(1, 1'b1, db);
      exp_b.push_back(da);
      exp_a.push_back(db);
      @(negedge clk);
      drive_tx(0, 1'b0, da);
      drive_tx(1, 1'b0, db);
   endtask

   task automatic wait_done();
      int i = 0;
      while (i < 5000 && !(got_a.size() >= exp_a.size() && got_b.size() >= exp_b.size() &&
                          got_c.size() >= exp_c.size() && rdy(0) === 1'b1 && rdy(1) === 1'b1)) begin
         @(negedge clk);
         i++;
      end
      repeat (4) @(negedge clk);
      verify_rx();
   endtask

   // Bench acting as the remote board towards instance c.
   task automatic remote_nibble(input logic [3:0] n);
      int i = 0;
      @(negedge clk);
      c_in[3:0] = n;
      @(negedge clk);
      c_in[5] = ~c_in[5];
      while (c_out[4] !== c_in[5] && i < 100) begin
         @(negedge clk);
         i++;
      end
      check("remote_ack", 32'(c_out[4]), 32'(c_in[5]));
   endtask

   task automatic remote_word(input logic [15:0] w);
      for (int k = 3; k >= 0; k--) remote_nibble(w[k*4 +: 4]);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int base_a5, base_b4, base_to_a, base_to_b, base_to_c, base_rx, edges, i;
      logic seen;
      logic [15:0] w;

      rst = 1'b1;
      c_in = '0;
      drive_tx(0, 1'b0, '0);
      drive_tx(1, 1'b0, '0);
      drive_tx(2, 1'b0, '0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_out_a",      32'(a_out), 32'd0);
      check("rst_out_c",      32'(c_out), 32'd0);
      check("rst_ready_a",    32'(if_a.tx_ready), 32'd1);
      check("rst_rx_data_a",  32'(if_a.rx_data), 32'd0);
      check("rst_rx_valid_b", 32'(if_b.rx_valid), 32'd0);
      check("rst_timeout_a",  32'(if_a.tx_timeout), 32'd0);

      // Loopback: a -> b
      base_a5 = tog_a5;
      base_b4 = tog_b4;
      send(0, 16'hA5C3);
      wait_done();
      check("loop_ready_a",  32'(if_a.tx_ready), 32'd1);
      check("loop_req_togs", 32'(tog_a5 - base_a5), 32'd4);
      check("loop_ack_togs", 32'(tog_b4 - base_b4), 32'd4);

      // Full duplex in the same cycle
      base_to_a = to_a;
      base_to_b = to_b;
      send_both(16'h1234, 16'hFEDC);
      wait_done();
      check("duplex_to_a", 32'(to_a - base_to_a), 32'd0);
      check("duplex_to_b", 32'(to_b - base_to_b), 32'd0);

      // Randomised traffic in both directions
      for (int it = 0; it < 24; it++) begin
         int mode;
         mode = $urandom_range(0, 2);
         case (mode)
            0:       send(0, 16'($urandom));
            1:       send(1, 16'($urandom));
            default: send_both(16'($urandom), 16'($urandom));
         endcase
         wait_done();
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      check("rand_to_a", 32'(to_a - base_to_a), 32'd0);
      check("rand_to_b", 32'(to_b - base_to_b), 32'd0);

      // Back-to-back with valid held high
      wait_ready(0);
      drive_tx(0, 1'b1, 16'h0001);
      exp_b.push_back(16'h0001);
      @(negedge clk);
      check("b2b_ready_drop", 32'(if_a.tx_ready), 32'd0);
      drive_tx(0, 1'b1, 16'hFFFF);
      exp_b.push_back(16'hFFFF);
      i = 0;
      while (if_a.tx_ready !== 1'b1 && i < 3000) begin
         @(negedge clk);
         i++;
      end
      @(negedge clk);
      check("b2b_second_accept", 32'(if_a.tx_ready), 32'd0);
      drive_tx(0, 1'b0, 16'hFFFF);
      wait_done();

      // TX timeout on c: remote pins tied to zero, never acks
      base_to_c = to_c;
      wait_ready(2);
      drive_tx(2, 1'b1, 16'h1357);
      @(posedge clk);
      @(negedge clk);
      drive_tx(2, 1'b0, 16'h1357);
      edges = 0;
      seen = 1'b0;
      while (!seen && edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (if_c.tx_timeout === 1'b1) seen = 1'b1;
      end
      // accept -> SETUP -> REQ -> TO_C cycles in WAIT_ACK -> pulse
      check("to_latency",  32'(edges), 32'(2 + TO_C));
      check("to_ready",    32'(if_c.tx_ready), 32'd1);
      check("to_req_high", 32'(c_out[5]), 32'd1);
      @(negedge clk);
      check("to_pulse_width", 32'(if_c.tx_timeout), 32'd0);
      check("to_ready_next",  32'(if_c.tx_ready), 32'd1);
      repeat (40) @(negedge clk);
      check("to_pulse_count", 32'(to_c - base_to_c), 32'd1);

      // RX partial frame on c, then a full frame
      base_rx = got_c.size();
      remote_nibble(4'($urandom));
      remote_nibble(4'($urandom));
      repeat (60) @(negedge clk);
      check("partial_no_valid", 32'(got_c.size()), 32'(base_rx));
      exp_c.push_back(16'h0F0F);
      remote_word(16'h0F0F);
      repeat (6) @(negedge clk);
      verify_rx();

      // Random frames from the bench-driven remote
      for (int it = 0; it < 4; it++) begin
         w = 16'($urandom);
         exp_c.push_back(w);
         remote_word(w);
      end
      repeat (6) @(negedge clk);
      verify_rx();

      // Reset during a's third nibble
      wait_done();
      base_a5 = tog_a5;
      send(0, 16'($urandom));
      i = 0;
      while (tog_a5 - base_a5 < 3 && i < 500) begin
         @(negedge clk);
         i++;
      end
      void'(exp_b.pop_back());
      base_rx   = got_b.size();
      base_to_a = to_a;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_out_a",   32'(a_out), 32'd0);
      check("mid_rst_out_b",   32'(b_out), 32'd0);
      check("mid_rst_ready_a", 32'(if_a.tx_ready), 32'd1);
      check("mid_rst_valid_b", 32'(if_b.rx_valid), 32'd0);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      check("mid_rst_no_rx", 32'(got_b.size()), 32'(base_rx));
      check("mid_rst_no_to", 32'(to_a - base_to_a), 32'd0);

      // Recovery after reset
      send(0, 16'hBEEF);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/battleship_link.md
Name: battleship_link

Overview:
- Point-to-point transceiver between the two boards of a game, carried on the 6-bit communication_input/communication_output pair at the battleship top level.
- Moves 16-bit game messages (shot coordinates, hit/miss/sunk replies) in both directions at once.
- Each message is sent as four 4-bit nibbles using a toggle request/acknowledge handshake.
- Sits between the game-logic controller (local tx/rx ports) and the board-to-board pins.

Parameters:
- TIMEOUT_CYCLES, 50000: cycles without remote progress before a TX abort or an RX partial-frame discard.
- SYNC_STAGES, 2: synchroniser depth on communication_input; minimum 2.

Ports:
- clk_clk  in  1  single system clock
- reset_reset  in  1  synchronous, active-high reset
- tx_data  in  16  message to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  block can accept a message
- tx_timeout  out  1  one-cycle pulse: message aborted, no ack received
- rx_data  out  16  last received message
- rx_valid  out  1  one-cycle pulse: rx_data updated
- communication_input  in  6  remote pins: [5] remote req, [4] remote ack, [3:0] remote nibble
- communication_output  out  6  local pins: [5] local req, [4] local ack, [3:0] local nibble

Behaviour:
- The reset is synchronous and active-high. Reset values:
  - communication_output = 6'b0
  - rx_data = 0
  - rx_valid = 0, tx_timeout = 0
  - TX FSM = IDLE, so tx_ready = 1 from the first cycle after reset
  - all counters and synchroniser flops = 0
- Reset asserted mid-frame aborts both directions immediately. No rx_valid and no tx_timeout pulse is produced.
- communication_input passes through SYNC_STAGES flops. All protocol decisions use the synchronised copy only.
- The TX FSM has four states: IDLE, SETUP, REQ, WAIT_ACK.
  - IDLE: tx_ready = 1. On tx_valid & tx_ready, latch tx_data, set nibble index = 0, go to SETUP. tx_ready drops in the following cycle.
  - SETUP: drive out[3:0] with the current nibble, MSB nibble first (tx_data[15:12] first). Hold for one cycle, then go to REQ. This guarantees data settles before req changes.
  - REQ: invert out[5], clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: the nibble is acknowledged when synced remote ack == out[5].
    - On ack, if the index is 3, go to IDLE; otherwise increment the index and go to SETUP.
    - If the counter reaches TIMEOUT_CYCLES-1 without an ack, pulse tx_timeout and go to IDLE. out[5] is left as is, so both sides stay phase-consistent.
  - out[3:0] holds its last value in IDLE.
- RX path:
  - A new nibble is present when synced remote req != out[4].
  - On that cycle: shift the synced remote nibble into a 16-bit shift register (left shift, new nibble in bits [3:0]), invert out[4], increment the RX nibble count.
  - When the 4th nibble is captured, rx_data takes the full word in the next cycle, together with a one-cycle rx_valid. The count then returns to 0.
  - Gap timeout: the RX gap counter runs while the count is nonzero. If it reaches TIMEOUT_CYCLES-1, the count and shift register clear and the partial frame is discarded with no pulse.
  - At most one nibble is captured per cycle. The next capture needs a fresh req toggle.
- Full duplex: TX and RX are independent.
  - out[5] is written only by TX; out[4] is written only by RX.
  - A simultaneous local send and remote receive in the same cycle needs no arbitration.
- Latency:
  - Accept to first req toggle: 2 cycles.
  - Per nibble, in loopback between two instances: about 2 + 2·SYNC_STAGES + 2 cycles.
- Counter widths: $clog2(TIMEOUT_CYCLES). Counters saturate and never wrap.

Test Plan:
- Loopback of two instances (A.out→B.in, B.out→A.in); A sends 16'hA5C3:
  - B pulses rx_valid once with rx_data = 16'hA5C3.
  - A's tx_ready returns high.
  - A's out[5] and B's out[4] toggle 4 times each.
- Full duplex: A sends 16'h1234 while B sends 16'hFEDC in the same cycle -> B receives 16'h1234, A receives 16'hFEDC, no timeouts.
- Remote tied off (input = 0, never acks), TIMEOUT_CYCLES = 16:
  - tx_timeout pulses exactly once, after the 16-cycle wait.
  - tx_ready = 1 the next cycle.
  - out[5] = 1 (one toggle).
- RX partial frame: drive 2 nibble toggles, then idle past the timeout, then send a full 4-nibble frame of 16'h0F0F -> exactly one rx_valid, rx_data = 16'h0F0F.
- Reset mid-message: assert reset_reset during A's 3rd nibble -> the next cycle shows communication_output = 0, tx_ready = 1, and no rx_valid or tx_timeout pulse.
- Back-to-back: A sends 16'h0001 then 16'hFFFF with tx_valid held high -> second accept occurs in the cycle tx_ready rises; B gets 2 rx_valid pulses in order.
